// File: rtl/dec_last_round.sv
// dec_last_round: last AES-128 decryption round with a 3-entry output FIFO.
// Optional macro DEC_LAST_ROUND_CNT_EN adds the 16-bit blk_cnt completed-block counter.
module dec_last_round #(
  parameter int BLOCK_LENGTH = 128  // only 128 is supported
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY1,
  input  logic [BLOCK_LENGTH-1:0] KEY0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT
`ifdef DEC_LAST_ROUND_CNT_EN
  ,
  output logic [15:0]             blk_cnt
`endif
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both 1.
  // in_ready depends on registered state only; out_valid/OUT hold until popped.

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (enough for 09/0b/0d/0e).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [BLOCK_LENGTH-1:0] w_ka;
  logic [BLOCK_LENGTH-1:0] w_imc;
  logic [BLOCK_LENGTH-1:0] w_isr;
  logic [BLOCK_LENGTH-1:0] w_isb;
  logic [BLOCK_LENGTH-1:0] w_push_data;

  logic                    r_s1_valid;
  logic [BLOCK_LENGTH-1:0] r_s1_state;
  logic [BLOCK_LENGTH-1:0] r_s1_key0;
  logic [BLOCK_LENGTH-1:0] r_mem [0:2];
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [1:0]              r_count;

  // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  assign w_ka = IN ^ KEY1;

  always_comb begin
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      w_imc[BLOCK_LENGTH-1-32*c -: 32] = inv_mix_col(w_ka[BLOCK_LENGTH-1-32*c -: 32]);
    end
  end

  // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
  always_comb begin
    w_isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[BLOCK_LENGTH-1-8*(4*c+r) -: 8] = w_imc[BLOCK_LENGTH-1-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    w_isb = '0;
    for (int i = 0; i < 16; i++) begin
      w_isb[BLOCK_LENGTH-1-8*i -: 8] = INV_SBOX[w_isr[BLOCK_LENGTH-1-8*i -: 8]];
    end
  end

  // Credits count both queued and in-flight blocks, so a stage-1 block always has a FIFO slot.
  assign in_ready    = ({1'b0, r_count} + {2'b00, r_s1_valid}) < 3'd3;
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign OUT         = out_valid ? r_mem[r_rd_ptr] : '0;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_s1_valid;
  assign w_push_data = r_s1_state ^ r_s1_key0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  // Stage-1 data is qualified by r_s1_valid, so it runs without reset or enable.
  always_ff @(posedge clk) begin
    r_s1_state <= w_isb;
    r_s1_key0  <= KEY0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DEC_LAST_ROUND_CNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blk_cnt <= 16'h0000;
    end else if (w_pop) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_dec_last_round.sv
// Scoreboard bench for dec_last_round: directed vectors, decoupled output monitor.
// Define DEC_LAST_ROUND_CNT_EN to also exercise the blk_cnt wrap.
`timescale 1ns/1ps
module tb_dec_last_round;

  localparam logic [127:0] C52 = {16{8'h52}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] IN = '0;
  logic [127:0] KEY1 = '0;
  logic [127:0] KEY0 = '0;
  logic [127:0] OUT;
`ifdef DEC_LAST_ROUND_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  int           pop_cyc [$];
  logic [127:0] bp_keys [0:3];

  dec_last_round #(.BLOCK_LENGTH(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN        (IN),
    .KEY1      (KEY1),
    .KEY0      (KEY0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT)
`ifdef DEC_LAST_ROUND_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d outputs outstanding, expected 0", exp_q.size());
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: a pop completes at the next posedge when out_valid && out_ready here
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out: got %h expected no output", OUT);
      end else begin
        check("scoreboard_out", OUT, exp_q.pop_front());
      end
    end
  end

  // driver: offer one block, wait (bounded) for acceptance, push its expected result
  task automatic send(input logic [127:0] d, input logic [127:0] k1, input logic [127:0] k0,
                      input logic [127:0] exp);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    IN = d;
    KEY1 = k1;
    KEY0 = k0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 50 cycles");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int guard;
    bp_keys[0] = {16{8'h11}};
    bp_keys[1] = {16{8'h22}};
    bp_keys[2] = {16{8'h33}};
    bp_keys[3] = {16{8'h44}};

    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_out_zero", OUT, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check1("release_out_valid", out_valid, 1'b0);
    check1("release_in_ready", in_ready, 1'b1);
`ifdef DEC_LAST_ROUND_CNT_EN
    check("release_blk_cnt", {112'h0, blk_cnt}, '0);
`endif
    @(posedge clk);
    #1;

    // IN == KEY1 gives a zero state, so OUT = 52..52 ^ KEY0; check the two-cycle latency
    out_ready = 1'b1;
    send(128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210, '0, C52);
    @(negedge clk);
    check1("latency_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check1("latency_cycle2_out_valid", out_valid, 1'b1);
    wait_drain();

    // uniform state bytes pass InvMixColumns/InvShiftRows unchanged
    send({16{8'hff}}, {16{8'hff}}, 128'h000102030405060708090a0b0c0d0e0f,
         C52 ^ 128'h000102030405060708090a0b0c0d0e0f);
    send({16{8'h7c}}, '0, '0, {16{8'h01}});
    send({16{8'hff}}, '0, {16{8'h0f}}, {16{8'h72}});
    send({16{8'h42}}, {16{8'h11}}, '0, {16{8'h50}});
    // one value per column: exposes the InvShiftRows direction
    send(128'h00000000636363637c7c7c7cffffffff, '0, '0, 128'h527d010000527d010100527d7d010052);
    // FIPS-197 C.1 last decryption round
    send(128'h89d810e8855ace682d1843d8cb128fe4, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
         128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    wait_drain();

    // backpressure: continuous in_valid with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      IN = {16{8'h5a}};
      KEY1 = {16{8'h5a}};
      KEY0 = bp_keys[acc];
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(C52 ^ KEY0);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_int("bp_accepted", acc, 3);
    @(negedge clk);
    check1("bp_in_ready_full", in_ready, 1'b0);
    check1("bp_out_valid", out_valid, 1'b1);
    check("bp_out_hold_a", OUT, C52 ^ bp_keys[0]);
    @(negedge clk);
    check("bp_out_hold_b", OUT, C52 ^ bp_keys[0]);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check1("bp_ready_before_pop", in_ready, 1'b0);
    @(negedge clk);
    check1("bp_ready_after_pop", in_ready, 1'b1);
    wait_drain();

    // streaming: 8 back-to-back blocks, 8 pops in consecutive cycles
    pop_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      IN = {16{8'hc3}};
      KEY1 = {16{8'hc3}};
      KEY0 = {16{8'(k + 1)}};
      @(negedge clk);
      check1("stream_in_ready", in_ready, 1'b1);
      exp_q.push_back(C52 ^ KEY0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check_int("stream_pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      check_int("stream_pop_span", pop_cyc[7] - pop_cyc[0], 7);
    end

    // reset with two blocks in flight: nothing may emerge afterwards
    out_ready = 1'b0;
    send({16{8'h99}}, {16{8'h99}}, {16{8'h01}}, C52 ^ {16{8'h01}});
    send({16{8'h98}}, {16{8'h98}}, {16{8'h02}}, C52 ^ {16{8'h02}});
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("rstmid_out_valid", out_valid, 1'b0);
      check("rstmid_out_zero", OUT, '0);
      check1("rstmid_in_ready", in_ready, 1'b1);
    end
`ifdef DEC_LAST_ROUND_CNT_EN
    check("rstmid_blk_cnt", {112'h0, blk_cnt}, '0);
`endif
    @(posedge clk);
    #1;
    send({16{8'h7c}}, '0, {16{8'h10}}, {16{8'h11}});
    wait_drain();

`ifdef DEC_LAST_ROUND_CNT_EN
    // counter wrap: 65535 pops after reset, then one more
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pop_cyc.delete();
    acc = 0;
    guard = 0;
    while (acc < 65535 && guard < 65635) begin
      in_valid = 1'b1;
      IN = {16{8'h3c}};
      KEY1 = {16{8'h3c}};
      KEY0 = {8{acc[15:0]}};
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(C52 ^ KEY0);
        acc++;
      end
      guard++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_int("cnt_accepted", acc, 65535);
    wait_drain();
    check("cnt_preload", {112'h0, blk_cnt}, {112'h0, 16'hffff});
    send({16{8'h3c}}, {16{8'h3c}}, '0, C52);
    wait_drain();
    check("cnt_wrap", {112'h0, blk_cnt}, '0);
`endif

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
